// File: rtl/paddle_controller.sv
// paddle_controller: turns raw up/down buttons into clamped paddle moves
// (synchronise, debounce, hold-to-repeat) and blanks the display enable for a
// fixed window after each ball hit so the renderer lights the whole column.
module paddle_controller #(
    parameter int WIDTH           = 4,
    parameter int BIT_WIDTH       = 2,
    parameter int PADDLE_LEN      = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 8,
    parameter int FLASH_CYCLES    = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 move_en,
    input  logic                 hit,
    output logic [BIT_WIDTH-1:0] state_left,
    output logic [BIT_WIDTH-1:0] state_right,
    output logic                 en
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam int FLS_W = $clog2(FLASH_CYCLES + 1);

    localparam logic [BIT_WIDTH-1:0] RST_LEFT  = BIT_WIDTH'((WIDTH - PADDLE_LEN) / 2);
    localparam logic [BIT_WIDTH-1:0] RST_RIGHT = BIT_WIDTH'((WIDTH - PADDLE_LEN) / 2 + PADDLE_LEN - 1);
    localparam logic [BIT_WIDTH-1:0] MAX_ROW   = BIT_WIDTH'(WIDTH - 1);
    localparam logic [BIT_WIDTH-1:0] ONE_ROW   = BIT_WIDTH'(1);
    localparam logic [DEB_W-1:0]     DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]     DEB_ONE   = DEB_W'(1);
    localparam logic [REP_W-1:0]     REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0]     REP_ONE   = REP_W'(1);
    localparam logic [FLS_W-1:0]     FLS_LOAD  = FLS_W'(FLASH_CYCLES);
    localparam logic [FLS_W-1:0]     FLS_ONE   = FLS_W'(1);

    typedef enum logic [1:0] {REQ_NONE, REQ_UP, REQ_DN} req_e;
    typedef enum logic {IDLE, HOLD} state_e;

    // Synchroniser stages
    logic up_meta_q, up_sync_q;
    logic dn_meta_q, dn_sync_q;

    // Debounce state
    logic             up_deb_q, up_deb_d;
    logic             dn_deb_q, dn_deb_d;
    logic [DEB_W-1:0] up_cnt_q, up_cnt_d;
    logic [DEB_W-1:0] dn_cnt_q, dn_cnt_d;

    // Move FSM state
    state_e               state_q;
    req_e                 dir_q;
    req_e                 req;
    logic [REP_W-1:0]     rep_cnt_q;
    logic [BIT_WIDTH-1:0] left_q, right_q;
    logic [BIT_WIDTH-1:0] left_step, right_step;

    // Flash state
    logic [FLS_W-1:0] flash_cnt_q;
    logic             en_q;

    // Two-flop synchronisers bring the asynchronous buttons into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_meta_q <= 1'b0;
            up_sync_q <= 1'b0;
            dn_meta_q <= 1'b0;
            dn_sync_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage capture the previous
            // stage's old value, so this really is a two-flop chain.
            up_meta_q <= btn_up;
            up_sync_q <= up_meta_q;
            dn_meta_q <= btn_down;
            dn_sync_q <= dn_meta_q;
        end
    end

    // Debounce next-state: count consecutive mismatch cycles, accept the new level on the last one.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        up_deb_d = up_deb_q;
        up_cnt_d = '0;
        dn_deb_d = dn_deb_q;
        dn_cnt_d = '0;
        if (up_sync_q != up_deb_q) begin
            if (up_cnt_q == DEB_LAST) up_deb_d = up_sync_q;
            else                      up_cnt_d = up_cnt_q + DEB_ONE;
        end
        if (dn_sync_q != dn_deb_q) begin
            if (dn_cnt_q == DEB_LAST) dn_deb_d = dn_sync_q;
            else                      dn_cnt_d = dn_cnt_q + DEB_ONE;
        end
    end

    // Debounce registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_deb_q <= 1'b0;
            up_cnt_q <= '0;
            dn_deb_q <= 1'b0;
            dn_cnt_q <= '0;
        end else begin
            up_deb_q <= up_deb_d;
            up_cnt_q <= up_cnt_d;
            dn_deb_q <= dn_deb_d;
            dn_cnt_q <= dn_cnt_d;
        end
    end

    // Direction decode: exactly one debounced button pressed gives a request.
    always_comb begin
        req = REQ_NONE;
        if (up_deb_q && !dn_deb_q)      req = REQ_UP;
        else if (dn_deb_q && !up_deb_q) req = REQ_DN;
    end

    // Candidate position after one step in the requested direction, clamped at the column ends.
    always_comb begin
        left_step  = left_q;
        right_step = right_q;
        if (req == REQ_UP && left_q != '0) begin
            left_step  = left_q - ONE_ROW;
            right_step = right_q - ONE_ROW;
        end else if (req == REQ_DN && right_q != MAX_ROW) begin
            left_step  = left_q + ONE_ROW;
            right_step = right_q + ONE_ROW;
        end
    end

    // Move FSM: first step on a new request, then one step every REPEAT_CYCLES while it is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dir_q     <= REQ_NONE;
            rep_cnt_q <= '0;
            left_q    <= RST_LEFT;
            right_q   <= RST_RIGHT;
        end else begin
            case (state_q)
                IDLE: begin
                    rep_cnt_q <= '0;
                    if (req != REQ_NONE && move_en) begin
                        left_q  <= left_step;
                        right_q <= right_step;
                        dir_q   <= req;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (req == dir_q && move_en) begin
                        if (rep_cnt_q == REP_LAST) begin
                            rep_cnt_q <= '0;
                            left_q    <= left_step;
                            right_q   <= right_step;
                        end else begin
                            rep_cnt_q <= rep_cnt_q + REP_ONE;
                        end
                    end else begin
                        // Any change passes through IDLE, so a reversal steps one cycle later.
                        rep_cnt_q <= '0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    rep_cnt_q <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // Flash window: a hit (re)loads the counter and holds en low until it runs out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_cnt_q <= '0;
            en_q        <= 1'b1;
        end else if (hit) begin
            flash_cnt_q <= FLS_LOAD;
            en_q        <= 1'b0;
        end else if (flash_cnt_q != '0) begin
            flash_cnt_q <= flash_cnt_q - FLS_ONE;
            en_q        <= (flash_cnt_q == FLS_ONE);
        end
    end

    assign state_left  = left_q;
    assign state_right = right_q;
    assign en          = en_q;

endmodule

// File: tb/tb_paddle_controller.sv
// tb_paddle_controller: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a behavioural model.
module tb_paddle_controller;

    localparam int WIDTH           = 4;
    localparam int BIT_WIDTH       = 2;
    localparam int PADDLE_LEN      = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int REPEAT_CYCLES   = 8;
    localparam int FLASH_CYCLES    = 6;
    localparam int RST_LEFT        = (WIDTH - PADDLE_LEN) / 2;
    localparam int MAX_LEFT        = WIDTH - PADDLE_LEN;

    logic                 clk;
    logic                 rst_n;
    logic                 btn_up;
    logic                 btn_down;
    logic                 move_en;
    logic                 hit;
    logic [BIT_WIDTH-1:0] state_left;
    logic [BIT_WIDTH-1:0] state_right;
    logic                 en;

    int n_checks = 0;
    int n_fail   = 0;

    paddle_controller #(
        .WIDTH          (WIDTH),
        .BIT_WIDTH      (BIT_WIDTH),
        .PADDLE_LEN     (PADDLE_LEN),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES),
        .FLASH_CYCLES   (FLASH_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .move_en    (move_en),
        .hit        (hit),
        .state_left (state_left),
        .state_right(state_right),
        .en         (en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_pos(input string name, input int left);
        check({name, " left"}, 32'(state_left), 32'(left));
        check({name, " right"}, 32'(state_right), 32'(left + PADDLE_LEN - 1));
    endtask

    // ---------------- behavioural model ----------------
    // Buttons are delayed two edges, accepted after DEBOUNCE_CYCLES stable
    // mismatching cycles; a held request steps at its start and every
    // REPEAT_CYCLES edges after; position is a clamped top row; en is low
    // while fewer than FLASH_CYCLES edges have passed since the last hit.
    bit m_sh1_up, m_sh2_up, m_sh1_dn, m_sh2_dn;
    bit m_deb_up, m_deb_dn;
    int m_run_up, m_run_dn;
    bit m_active;
    int m_dir;
    int m_age;
    int m_left;
    int m_edge;
    int m_last_hit;
    bit m_en;

    task automatic model_reset();
        m_sh1_up = 0; m_sh2_up = 0; m_sh1_dn = 0; m_sh2_dn = 0;
        m_deb_up = 0; m_deb_dn = 0; m_run_up = 0; m_run_dn = 0;
        m_active = 0; m_dir = 0; m_age = 0;
        m_left = RST_LEFT;
        m_edge = 0; m_last_hit = -1000; m_en = 1;
    endtask

    initial model_reset();

    always @(posedge clk) begin : model
        int  req;
        bit  step_now;
        if (!rst_n) begin
            model_reset();
        end else begin
            req = 0;
            if (m_deb_up && !m_deb_dn) req = -1;
            if (m_deb_dn && !m_deb_up) req = 1;
            step_now = 0;
            if (m_active) begin
                if (req == m_dir && move_en) begin
                    m_age++;
                    step_now = (m_age % REPEAT_CYCLES) == 0;
                end else begin
                    m_active = 0;
                end
            end else if (req != 0 && move_en) begin
                m_active = 1;
                m_dir    = req;
                m_age    = 0;
                step_now = 1;
            end
            if (step_now) begin
                m_left = m_left + req;
                if (m_left < 0) m_left = 0;
                if (m_left > MAX_LEFT) m_left = MAX_LEFT;
            end
            if (m_sh2_up != m_deb_up) begin
                m_run_up++;
                if (m_run_up == DEBOUNCE_CYCLES) begin m_deb_up = m_sh2_up; m_run_up = 0; end
            end else m_run_up = 0;
            if (m_sh2_dn != m_deb_dn) begin
                m_run_dn++;
                if (m_run_dn == DEBOUNCE_CYCLES) begin m_deb_dn = m_sh2_dn; m_run_dn = 0; end
            end else m_run_dn = 0;
            m_sh2_up = m_sh1_up; m_sh1_up = btn_up;
            m_sh2_dn = m_sh1_dn; m_sh1_dn = btn_down;
            m_edge++;
            if (hit) m_last_hit = m_edge;
            m_en = !((m_edge - m_last_hit) < FLASH_CYCLES);
        end
    end

    // Compare DUT against the model (or reset values) on every falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("cmp rst left", 32'(state_left), 32'(RST_LEFT));
            check("cmp rst right", 32'(state_right), 32'(RST_LEFT + PADDLE_LEN - 1));
            check("cmp rst en", 32'(en), 32'd1);
        end else begin
            check("cmp left", 32'(state_left), 32'(m_left));
            check("cmp right", 32'(state_right), 32'(m_left + PADDLE_LEN - 1));
            check("cmp en", 32'(en), 32'(m_en));
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int up_hold;
        int dn_hold;
        btn_up = 0; btn_down = 0; move_en = 1; hit = 0;
        rst_n = 1;
        #2 rst_n = 0;
        #1;
        check_pos("reset", 1);
        check("reset en", 32'(en), 32'd1);
        tick(2);
        rst_n = 1;

        tick(50);
        check_pos("idle 50", 1);
        check("idle en", 32'(en), 32'd1);

        // Clean btn_down: first step on edge 7, repeat clamps at the bottom.
        btn_down = 1;
        tick(6);
        check_pos("down edge6", 1);
        tick(1);
        check_pos("down edge7", 2);
        tick(23);
        check_pos("down held 30", 2);
        btn_down = 0;
        tick(20);
        btn_up = 1;
        tick(6);
        check_pos("up edge6", 2);
        tick(1);
        check_pos("up edge7", 1);
        btn_up = 0;
        tick(20);

        // Short glitches are filtered; a 4-cycle pulse gives exactly one step.
        for (int len = 1; len <= 4; len++) begin
            btn_up = 1;
            tick(len);
            btn_up = 0;
            tick(20);
            check_pos($sformatf("glitch len%0d", len), (len < DEBOUNCE_CYCLES) ? 1 : 0);
        end

        // Both held from reset: no request until btn_down is released.
        rst_n = 0;
        btn_up = 1; btn_down = 1;
        tick(2);
        rst_n = 1;
        tick(40);
        check_pos("both held", 1);
        btn_down = 0;
        tick(6);
        check_pos("release dn edge6", 1);
        tick(1);
        check_pos("release dn edge7", 0);
        tick(30);
        check_pos("up clamped", 0);
        btn_up = 0;
        tick(20);

        // Single hit, then a retriggered flash.
        for (int k = 0; k < 8; k++) begin
            hit = (k == 0);
            tick(1);
            check($sformatf("flash1 k%0d", k), 32'(en), 32'(k >= FLASH_CYCLES));
        end
        for (int k = 0; k < 11; k++) begin
            hit = (k == 0 || k == 3);
            tick(1);
            check($sformatf("flash2 k%0d", k), 32'(en), 32'(k >= 3 + FLASH_CYCLES));
        end
        hit = 0;

        // move_en gates movement; raising it steps on the next edge.
        move_en = 0;
        btn_down = 1;
        tick(30);
        check_pos("move_en low", 0);
        move_en = 1;
        tick(1);
        check_pos("move_en raised", 1);
        tick(7);
        check_pos("hold before repeat", 1);
        tick(1);
        check_pos("repeat step", 2);

        // Asynchronous reset mid-hold and mid-flash.
        hit = 1;
        tick(1);
        hit = 0;
        tick(2);
        check("pre-reset en", 32'(en), 32'd0);
        #2 rst_n = 0;
        #1;
        check_pos("async reset", 1);
        check("async reset en", 32'(en), 32'd1);
        tick(2);
        btn_down = 0;
        rst_n = 1;
        tick(20);

        // Randomized phase, checked by the model every cycle.
        up_hold = 0;
        dn_hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (up_hold == 0) begin btn_up = 1'($urandom_range(0, 1)); up_hold = $urandom_range(1, 24); end
            else up_hold--;
            if (dn_hold == 0) begin btn_down = 1'($urandom_range(0, 1)); dn_hold = $urandom_range(1, 24); end
            else dn_hold--;
            if ($urandom_range(0, 59) == 0) move_en = ~move_en;
            hit = ($urandom_range(0, 29) == 0);
            if (c == 2000) rst_n = 0;
            if (c == 2001) rst_n = 1;
            tick(1);
        end
        btn_up = 0; btn_down = 0; hit = 0; move_en = 1;
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
